// File: rtl/queen_pkg.sv
// Shared constants, types and FSM state encoding for the N-queen search controller.
package queen_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned SIZE  = 2 * LOG2N;

  typedef logic [LOG2N-1:0] pos_t;

  typedef struct packed {
    pos_t row;
    pos_t col;
  } entry_t;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StPlace,
    StBack,
    StPopReq,
    StPopWait,
    StSolved,
    StFinish
  } state_e;

endpackage

// File: rtl/queen_conflict_check.sv
// Combinational attack test: does a queen at (i_row, i_col) clash with any queen placed in a
// row above it? Only rows p < i_row are considered; entries at or below i_row may be stale.
module queen_conflict_check #(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG2N = 3
) (
  input  logic [N*LOG2N-1:0] i_cols,
  input  logic [LOG2N-1:0]   i_row,
  input  logic [LOG2N-1:0]   i_col,
  output logic               o_conflict
);
  import queen_pkg::*;

  logic [LOG2N-1:0] w_pcol;
  logic [LOG2N:0]   w_dr;
  logic [LOG2N:0]   w_dc;

  // Same column or same diagonal against every earlier row; distances kept one bit wider.
  always_comb begin
    o_conflict = 1'b0;
    w_pcol     = '0;
    w_dr       = '0;
    w_dc       = '0;
    for (int unsigned p = 0; p < N; p++) begin
      w_pcol = i_cols[LOG2N*p +: LOG2N];
      w_dr   = {1'b0, i_row} - (LOG2N+1)'(p);
      w_dc   = (i_col >= w_pcol) ? ({1'b0, i_col} - {1'b0, w_pcol})
                                 : ({1'b0, w_pcol} - {1'b0, i_col});
      if (((LOG2N+1)'(p) < {1'b0, i_row}) && ((w_pcol == i_col) || (w_dr == w_dc))) begin
        o_conflict = 1'b1;
      end
    end
  end

endmodule

// File: rtl/queen_search_ctrl.sv
// Backtracking N-queen search controller driving an external LIFO stack.
// Searches row-major, columns ascending, and reports solutions as a packed board.
// Optional macro ALL_SOLUTIONS_EN: enumerate every solution and add o_sol_count; when
// undefined the search stops at the first solution.
module queen_search_ctrl #(
  parameter int unsigned N     = queen_pkg::N,
  parameter int unsigned LOG2N = queen_pkg::LOG2N,
  parameter int unsigned SIZE  = queen_pkg::SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_found,
  output logic               o_sol_valid,
  output logic [N*LOG2N-1:0] o_sol_board,
  output logic               o_stk_push,
  output logic               o_stk_pop,
  output logic [SIZE-1:0]    o_stk_in_data,
  input  logic [SIZE-1:0]    i_stk_out_data
`ifdef ALL_SOLUTIONS_EN
  ,
  output logic [15:0]        o_sol_count
`endif
);
  import queen_pkg::*;

  localparam logic [LOG2N-1:0] LastPos = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] OnePos  = LOG2N'(1);

  state_e             r_state;
  logic [LOG2N-1:0]   r_row;
  logic [LOG2N-1:0]   r_col;
  logic [N*LOG2N-1:0] r_cols;
  logic               r_busy;
  logic               r_done;
  logic               r_found;
  logic               r_sol_valid;
  logic [N*LOG2N-1:0] r_sol_board;
  logic               r_stk_push;
  logic               r_stk_pop;
  logic [SIZE-1:0]    r_stk_in_data;
`ifdef ALL_SOLUTIONS_EN
  logic [15:0]        r_sol_count;
`endif

  logic               w_conflict;
  logic [N*LOG2N-1:0] w_board;
  logic [LOG2N-1:0]   w_pop_row;
  logic [LOG2N-1:0]   w_pop_col;

  assign w_pop_row = i_stk_out_data[SIZE-1 -: LOG2N];
  assign w_pop_col = i_stk_out_data[LOG2N-1:0];

  queen_conflict_check #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_conflict (
    .i_cols     (r_cols),
    .i_row      (r_row),
    .i_col      (r_col),
    .o_conflict (w_conflict)
  );

  // Column array with the current (row, col) placed; written back in PLACE.
  always_comb begin
    w_board                      = r_cols;
    w_board[LOG2N*r_row +: LOG2N] = r_col;
  end

  // Search FSM; pulse outputs are set on entry to the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_row         <= '0;
      r_col         <= '0;
      r_cols        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_found       <= 1'b0;
      r_sol_valid   <= 1'b0;
      r_sol_board   <= '0;
      r_stk_push    <= 1'b0;
      r_stk_pop     <= 1'b0;
      r_stk_in_data <= '0;
`ifdef ALL_SOLUTIONS_EN
      r_sol_count   <= '0;
`endif
    end else begin
      r_stk_push  <= 1'b0;
      r_stk_pop   <= 1'b0;
      r_sol_valid <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StCheck;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_found <= 1'b0;
`ifdef ALL_SOLUTIONS_EN
            r_sol_count <= '0;
`endif
          end
        end
        StCheck: begin
          if (!w_conflict) begin
            r_state       <= StPlace;
            r_stk_push    <= 1'b1;
            r_stk_in_data <= {r_row, r_col};
          end else if (r_col != LastPos) begin
            r_col <= r_col + OnePos;
          end else begin
            r_state <= StBack;
          end
        end
        StPlace: begin
          r_cols <= w_board;
          if (r_row == LastPos) begin
            r_state     <= StSolved;
            r_sol_valid <= 1'b1;
            r_sol_board <= w_board;
            r_found     <= 1'b1;
`ifdef ALL_SOLUTIONS_EN
            r_sol_count <= r_sol_count + 16'd1;
`endif
          end else begin
            r_state <= StCheck;
            r_row   <= r_row + OnePos;
            r_col   <= '0;
          end
        end
        StBack: begin
          // Row 0 exhausted means the stack is already empty: never pop here.
          if (r_row == '0) begin
            r_state <= StFinish;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= StPopReq;
            r_stk_pop <= 1'b1;
          end
        end
        StPopReq: begin
          r_state <= StPopWait;
        end
        StPopWait: begin
          r_row <= w_pop_row;
          if (w_pop_col == LastPos) begin
            r_state <= StBack;
          end else begin
            r_state <= StCheck;
            r_col   <= w_pop_col + OnePos;
          end
        end
        StSolved: begin
`ifdef ALL_SOLUTIONS_EN
          // Undo the last placement and resume at its next column.
          r_state   <= StPopReq;
          r_stk_pop <= 1'b1;
`else
          r_state <= StFinish;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
`endif
        end
        StFinish: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_found       = r_found;
  assign o_sol_valid   = r_sol_valid;
  assign o_sol_board   = r_sol_board;
  assign o_stk_push    = r_stk_push;
  assign o_stk_pop     = r_stk_pop;
  assign o_stk_in_data = r_stk_in_data;
`ifdef ALL_SOLUTIONS_EN
  assign o_sol_count   = r_sol_count;
`endif

endmodule

// File: tb/tb_queen_search_ctrl.sv
// Bench for queen_search_ctrl: four instances (N = 8, 4, 3, 2), each with a LIFO stack model,
// compared against a permutation-enumeration model of the N-queen problem.
module tb_queen_search_ctrl;

  localparam int NI     = 4;
  localparam int Budget = 60000;
`ifdef ALL_SOLUTIONS_EN
  localparam int KBig = 1;
`else
  localparam int KBig = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a [NI];
  logic        busy_a  [NI];
  logic        done_a  [NI];
  logic        found_a [NI];
  logic        sv_a    [NI];
  logic        push_a  [NI];
  logic        pop_a   [NI];
  logic [23:0] board_a [NI];
  logic [5:0]  in_a    [NI];
  int          sp_a    [NI];
  int          viol_a  [NI];
`ifdef ALL_SOLUTIONS_EN
  logic [15:0] cnt_a   [NI];
`endif

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_sols[$];
  logic [23:0] got[$];
  logic        run_found;
  logic        run_timeout;
  logic        run_busy_start;
  logic        run_busy_done;
  int          run_sp;

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int NK = (k == 0) ? 8 : (k == 1) ? 4 : (k == 2) ? 3 : 2;
    localparam int LG = $clog2(NK);

    logic              w_busy, w_done, w_found, w_sv, w_push, w_pop;
    logic [NK*LG-1:0]  w_board;
    logic [2*LG-1:0]   w_in;
    logic [2*LG-1:0]   r_out;
    logic [2*LG-1:0]   mem [NK];
    int                r_sp   = 0;
    int                r_viol = 0;
`ifdef ALL_SOLUTIONS_EN
    logic [15:0]       w_cnt;
    assign cnt_a[k] = w_cnt;
`endif

    queen_search_ctrl #(
      .N     (NK),
      .LOG2N (LG),
      .SIZE  (2 * LG)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .i_start        (start_a[k]),
      .o_busy         (w_busy),
      .o_done         (w_done),
      .o_found        (w_found),
      .o_sol_valid    (w_sv),
      .o_sol_board    (w_board),
      .o_stk_push     (w_push),
      .o_stk_pop      (w_pop),
      .o_stk_in_data  (w_in),
      .i_stk_out_data (r_out)
`ifdef ALL_SOLUTIONS_EN
      ,
      .o_sol_count    (w_cnt)
`endif
    );

    assign busy_a[k]  = w_busy;
    assign done_a[k]  = w_done;
    assign found_a[k] = w_found;
    assign sv_a[k]    = w_sv;
    assign push_a[k]  = w_push;
    assign pop_a[k]   = w_pop;
    assign board_a[k] = 24'(w_board);
    assign in_a[k]    = 6'(w_in);
    assign sp_a[k]    = r_sp;
    assign viol_a[k]  = r_viol;

    // LIFO of depth NK; counts overlap, underflow and overflow as protocol violations.
    always @(posedge clk) begin
      if (reset) begin
        r_sp  <= 0;
        r_out <= '0;
      end else if (w_push && w_pop) begin
        r_viol <= r_viol + 1;
      end else if (w_push) begin
        if (r_sp >= NK) r_viol <= r_viol + 1;
        else begin
          mem[r_sp] <= w_in;
          r_sp      <= r_sp + 1;
        end
      end else if (w_pop) begin
        if (r_sp == 0) r_viol <= r_viol + 1;
        else begin
          r_out <= mem[r_sp-1];
          r_sp  <= r_sp - 1;
        end
      end
    end
  end

  function automatic int n_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : (k == 2) ? 3 : 2;
  endfunction

  function automatic int lg_of(input int k);
    return $clog2(n_of(k));
  endfunction

  function automatic logic [23:0] pack_board(input int c[8], input int n, input int lg);
    logic [23:0] b = '0;
    for (int r = 0; r < n; r++) b = b | (24'(c[r]) << (lg * r));
    return b;
  endfunction

  // Every permutation in lexicographic order, kept if no two queens share a diagonal.
  function automatic void build_model(input int n, input int lg);
    int p[8];
    bit more = 1'b1;
    bit ok;
    int i, j, l, r, t, d;
    exp_sols.delete();
    for (int q = 0; q < 8; q++) p[q] = q;
    while (more) begin
      ok = 1'b1;
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++) begin
          d = p[b] - p[a];
          if (d < 0) d = -d;
          if (d == b - a) ok = 1'b0;
        end
      if (ok) exp_sols.push_back(pack_board(p, n, lg));
      i = n - 2;
      while (i >= 0 && p[i] > p[i+1]) i--;
      if (i < 0) more = 1'b0;
      else begin
        j = n - 1;
        while (p[j] < p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        l = i + 1;
        r = n - 1;
        while (l < r) begin
          t = p[l]; p[l] = p[r]; p[r] = t;
          l++;
          r--;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NI; k++) start_a[k] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_search(input int k, input bit repulse);
    got.delete();
    run_timeout    = 1'b1;
    run_found      = 1'b0;
    run_busy_done  = 1'b1;
    run_sp         = -1;
    @(negedge clk);
    start_a[k] = 1'b1;
    @(negedge clk);
    start_a[k] = 1'b0;
    run_busy_start = busy_a[k];
    for (int c = 0; c < Budget; c++) begin
      @(negedge clk);
      if (sv_a[k]) got.push_back(board_a[k]);
      if (done_a[k]) begin
        run_timeout   = 1'b0;
        run_found     = found_a[k];
        run_busy_done = busy_a[k];
        run_sp        = sp_a[k];
        start_a[k]    = 1'b0;
        break;
      end
      start_a[k] = repulse && ($urandom_range(0, 7) == 0);
    end
    start_a[k] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({busy_a[k], done_a[k], found_a[k], sv_a[k], push_a[k], pop_a[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b want 000000", k,
                 {busy_a[k], done_a[k], found_a[k], sv_a[k], push_a[k], pop_a[k]});
      end
      checks++;
      if (board_a[k] !== 24'h0) begin
        errors++;
        $display("FAIL reset_board[%0d]: got %h want 0", k, board_a[k]);
      end
      checks++;
      if (in_a[k] !== 6'h0) begin
        errors++;
        $display("FAIL reset_in_data[%0d]: got %h want 0", k, in_a[k]);
      end
    end
  endtask

  task automatic test_search(input int k, input bit repulse, input string name);
    int n = n_of(k);
    int lg = lg_of(k);
    int exp_pulses;
    int exp_sp;
    int kn[8];
    logic [23:0] first;
    build_model(n, lg);
    run_search(k, repulse);
`ifdef ALL_SOLUTIONS_EN
    exp_pulses = exp_sols.size();
    exp_sp     = 0;
`else
    exp_pulses = (exp_sols.size() > 0) ? 1 : 0;
    exp_sp     = (exp_sols.size() > 0) ? n : 0;
`endif
    checks++;
    if (run_timeout) begin
      errors++;
      $display("FAIL %s done_timeout: got no done in %0d cycles want done", name, Budget);
    end
    checks++;
    if (run_busy_start !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %b want 1", name, run_busy_start);
    end
    checks++;
    if (run_busy_done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b want 0", name, run_busy_done);
    end
    checks++;
    if (run_found !== (exp_sols.size() > 0)) begin
      errors++;
      $display("FAIL %s found: got %b want %0d", name, run_found, exp_sols.size() > 0);
    end
    checks++;
    if (got.size() != exp_pulses) begin
      errors++;
      $display("FAIL %s sol_valid_pulses: got %0d want %0d", name, got.size(), exp_pulses);
    end
    for (int i = 0; i < got.size() && i < exp_sols.size(); i++) begin
      checks++;
      if (got[i] !== exp_sols[i]) begin
        errors++;
        $display("FAIL %s board[%0d]: got %h want %h", name, i, got[i], exp_sols[i]);
      end
    end
    checks++;
    if (run_sp != exp_sp) begin
      errors++;
      $display("FAIL %s stack_occupancy_at_done: got %0d want %0d", name, run_sp, exp_sp);
    end
    checks++;
    if (viol_a[k] != 0) begin
      errors++;
      $display("FAIL %s stack_protocol: got %0d violations want 0", name, viol_a[k]);
    end
`ifdef ALL_SOLUTIONS_EN
    checks++;
    if (cnt_a[k] !== 16'(exp_sols.size())) begin
      errors++;
      $display("FAIL %s sol_count: got %0d want %0d", name, cnt_a[k], exp_sols.size());
    end
`endif
    first = (got.size() > 0) ? got[0] : 24'hffffff;
    if (k == 0) begin
      kn = '{0, 4, 7, 5, 2, 6, 1, 3};
      checks++;
      if (first !== pack_board(kn, 8, 3)) begin
        errors++;
        $display("FAIL %s known_n8_board: got %h want %h", name, first, pack_board(kn, 8, 3));
      end
    end else if (k == 1) begin
      kn = '{1, 3, 0, 2, 0, 0, 0, 0};
      checks++;
      if (first !== pack_board(kn, 4, 2)) begin
        errors++;
        $display("FAIL %s known_n4_board: got %h want %h", name, first, pack_board(kn, 4, 2));
      end
    end
  endtask

  task automatic test_reset_mid();
    int wait_cyc = 50 + int'($urandom_range(0, 30));
    bit saw_done = 1'b0;
    do_reset();
    @(negedge clk);
    start_a[KBig] = 1'b1;
    @(negedge clk);
    start_a[KBig] = 1'b0;
    for (int c = 0; c < wait_cyc; c++) begin
      @(negedge clk);
      if (done_a[KBig]) saw_done = 1'b1;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL mid_reset_early_done: got done before reset want none");
    end
    checks++;
    if ({busy_a[KBig], done_a[KBig], found_a[KBig], sv_a[KBig], push_a[KBig], pop_a[KBig]}
        !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b want 000000",
               {busy_a[KBig], done_a[KBig], found_a[KBig], sv_a[KBig], push_a[KBig], pop_a[KBig]});
    end
    checks++;
    if (board_a[KBig] !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset_board: got %h want 0", board_a[KBig]);
    end
    reset = 1'b0;
    test_search(KBig, 1'b0, "after_mid_reset");
  endtask

  task automatic test_repulse();
    do_reset();
    test_search(KBig, 1'b1, "start_repulse");
  endtask

  task automatic test_found_hold();
    do_reset();
    test_search(KBig, 1'b0, "found_hold_run");
    repeat ($urandom_range(2, 20)) @(negedge clk);
    checks++;
    if ({found_a[KBig], busy_a[KBig], done_a[KBig]} !== 3'b100) begin
      errors++;
      $display("FAIL found_hold: got found/busy/done %b want 100",
               {found_a[KBig], busy_a[KBig], done_a[KBig]});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    test_search(2, 1'b0, "n3_first");
    test_search(2, 1'b0, "n3_again");
    test_search(3, 1'b0, "n2_first");
    test_search(3, 1'b0, "n2_again");
`ifdef ALL_SOLUTIONS_EN
    test_search(1, 1'b0, "n4_first");
    test_search(1, 1'b0, "n4_again");
`endif
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NI; k++) start_a[k] = 1'b0;
    test_reset();
    do_reset();
    test_search(0, 1'b0, "n8");
    do_reset();
    test_search(1, 1'b0, "n4");
    do_reset();
    test_search(2, 1'b0, "n3");
    do_reset();
    test_search(3, 1'b0, "n2");
    test_reset_mid();
    test_repulse();
    test_found_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
